// File: rtl/draw_request_scheduler.sv
// Round-robin scheduler sharing one sprite drawer among NUM_REQ requesters.
// Issues a one-cycle draw strobe, tracks the drawer's ready handshake, then acks the granted requester.
module draw_request_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GW             = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [8*NUM_REQ-1:0]   reqX,
  input  logic [9*NUM_REQ-1:0]   reqY,
  input  logic [8*NUM_REQ-1:0]   reqMif,
  output logic [NUM_REQ-1:0]     reqAck,
  input  logic                   drawReady,
  output logic                   draw,
  output logic [7:0]             xOrigin,
  output logic [8:0]             yOrigin,
  output logic [7:0]             mifId,
  output logic                   busy,
  output logic [GW-1:0]          grantId,
  output logic                   timeoutErr
);

  localparam int unsigned CW = 8;
  // Counter value on which one more ready-high sample means the drawer ignored the strobe.
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    ACK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 draw_q, draw_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           x_q, x_d;
  logic [8:0]           y_q, y_d;
  logic [7:0]           mif_q, mif_d;
  logic                 busy_q, busy_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 terr_q, terr_d;

  logic [7:0]           x_arr   [NUM_REQ];
  logic [8:0]           y_arr   [NUM_REQ];
  logic [7:0]           mif_arr [NUM_REQ];
  logic                 sel_found;
  logic [GW-1:0]        sel_idx;
  logic [GW-1:0]        cand;

  // Split the flat request buses into per-requester fields.
  always_comb begin : unpack
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      x_arr[i]   = reqX[8*i +: 8];
      y_arr[i]   = reqY[9*i +: 9];
      mif_arr[i] = reqMif[8*i +: 8];
    end
  end

  // First pending requester after the last grant, wrapping around.
  always_comb begin : rr_search
    sel_found = 1'b0;
    sel_idx   = grant_q;
    cand      = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = GW'((int'(grant_q) + i) % int'(NUM_REQ));
      if (!sel_found && reqValid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    draw_d  = 1'b0;
    ack_d   = '0;
    x_d     = x_q;
    y_d     = y_q;
    mif_d   = mif_q;
    grant_d = grant_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (drawReady && sel_found) begin
          state_d = ISSUE;
          grant_d = sel_idx;
          x_d     = x_arr[sel_idx];
          y_d     = y_arr[sel_idx];
          mif_d   = mif_arr[sel_idx];
          draw_d  = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      WAIT_START: begin
        if (!drawReady) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Drawer never left ready: flag it, but still ack so the requester is released.
          terr_d         = 1'b1;
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (drawReady) begin
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin : regs
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      draw_q  <= 1'b0;
      ack_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mif_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= GRANT_RST;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      draw_q  <= draw_d;
      ack_q   <= ack_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mif_q   <= mif_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      terr_q  <= terr_d;
    end
  end

  assign draw       = draw_q;
  assign reqAck     = ack_q;
  assign xOrigin    = x_q;
  assign yOrigin    = y_q;
  assign mifId      = mif_q;
  assign busy       = busy_q;
  assign grantId    = grant_q;
  assign timeoutErr = terr_q;

endmodule

// File: tb/tb_draw_request_scheduler.sv
// Bench for draw_request_scheduler: the bench plays the drawer and the requesters,
// predicting grants, ack timing and timeout from a round-robin / handshake model.
module tb_draw_request_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_x;
  logic [9*N-1:0] req_y;
  logic [8*N-1:0] req_mif;
  logic [N-1:0]  req_ack;
  logic          draw_ready;
  logic          draw;
  logic [7:0]    x_origin;
  logic [8:0]    y_origin;
  logic [7:0]    mif_id;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout_err;

  logic [7:0] xs [N];
  logic [8:0] ys [N];
  logic [7:0] ms [N];

  int  checks = 0;
  int  errors = 0;
  int  last_g;
  bit  exp_terr;

  assign req_x   = {xs[3], xs[2], xs[1], xs[0]};
  assign req_y   = {ys[3], ys[2], ys[1], ys[0]};
  assign req_mif = {ms[3], ms[2], ms[1], ms[0]};

  draw_request_scheduler #(.NUM_REQ(N), .GW(2), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (req_valid),
    .reqX       (req_x),
    .reqY       (req_y),
    .reqMif     (req_mif),
    .reqAck     (req_ack),
    .drawReady  (draw_ready),
    .draw       (draw),
    .xOrigin    (x_origin),
    .yOrigin    (y_origin),
    .mifId      (mif_id),
    .busy       (busy),
    .grantId    (grant_id),
    .timeoutErr (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Round-robin rule: first pending requester after the previous grant.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    int vi;
    vi = int'(v);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (((vi >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      xs[i] = 8'($urandom);
      ys[i] = 9'($urandom);
      ms[i] = 8'($urandom);
    end
  endtask

  // One full draw: wait for strobe, act as drawer (ready high for hi samples, low for lo), check ack.
  task automatic xact(input int hi, input int lo, input int exp_lat, input bit drop_valid);
    int g, lat, ack_t, exp_ack_t, extra;
    bit stable_ok;
    g   = rr_pick(last_g, req_valid);
    lat = 0;
    while (draw !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("draw_latency", lat, exp_lat);
    chk("grant_id", 32'(grant_id), g);
    chk("x_origin", 32'(x_origin), 32'(xs[g]));
    chk("y_origin", 32'(y_origin), 32'(ys[g]));
    chk("mif_id", 32'(mif_id), 32'(ms[g]));
    chk("busy_issue", 32'(busy), 1);
    last_g = g;
    if (drop_valid) req_valid = '0;
    ack_t = 0;
    extra = 0;
    stable_ok = 1'b1;
    for (int t = 1; t <= 300 && ack_t == 0; t++) begin
      draw_ready = ((t - 1) <= hi) || ((t - 1) > hi + lo);
      tick();
      if (draw === 1'b1) extra++;
      if (x_origin !== xs[g] || y_origin !== ys[g] || mif_id !== ms[g]) stable_ok = 1'b0;
      if (req_ack !== '0) ack_t = t;
    end
    exp_ack_t = (hi >= TO - 1) ? TO : hi + lo + 2;
    if (hi >= TO - 1) exp_terr = 1'b1;
    chk("ack_cycle", ack_t, exp_ack_t);
    chk("ack_vector", 32'(req_ack), 32'(1) << g);
    chk("single_draw", extra, 0);
    chk("coords_stable", 32'(stable_ok), 1);
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
    chk("busy_ack", 32'(busy), 1);
    draw_ready = 1'b1;
    tick();
    chk("ack_one_cycle", 32'(req_ack), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int hi, lo;
    reset      = 1'b1;
    req_valid  = '0;
    draw_ready = 1'b1;
    last_g     = N - 1;
    exp_terr   = 1'b0;
    randomize_data();
    tick();
    tick();
    chk("rst_draw", 32'(draw), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_x", 32'(x_origin), 0);
    chk("rst_y", 32'(y_origin), 0);
    chk("rst_mif", 32'(mif_id), 0);
    chk("rst_grant", 32'(grant_id), N - 1);

    // Single request from requester 2 with fixed coordinates.
    reset     = 1'b0;
    xs[2]     = 8'd20;
    ys[2]     = 9'd20;
    ms[2]     = 8'd1;
    req_valid = 4'b0100;
    xact(2, 10, 1, 1'b0);

    // All requesters pending from reset: strict rotation.
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    last_g = N - 1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      randomize_data();
      chk("rotation_order", rr_pick(last_g, req_valid), i % N);
      xact(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1, 1'b0);
    end

    // Wrap-around: after granting 0, pattern 1001 gives 3 then 0.
    req_valid = 4'b0001;
    xact(0, 1, 1, 1'b0);
    req_valid = 4'b1001;
    xact(0, 1, 1, 1'b0);
    chk("wrap_grant3", 32'(grant_id), 3);
    xact(1, 1, 1, 1'b0);
    chk("wrap_grant0", 32'(grant_id), 0);

    // Drawer busy while idle: no strobe until ready returns.
    randomize_data();
    draw_ready = 1'b0;
    req_valid  = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_draw", 32'(draw), 0);
    end
    chk("idle_not_busy", 32'(busy), 0);
    draw_ready = 1'b1;
    xact(1, 2, 1, 1'b0);

    // Timeout boundary: one short of the limit, then exactly at it, then sticky.
    req_valid = 4'b1111;
    xact(TO - 2, 1, 1, 1'b0);
    xact(TO - 1, 1, 1, 1'b0);
    xact(0, 2, 1, 1'b0);
    xact(2, 1, 1, 1'b1);

    // Reset during WAIT_DONE: everything back to reset values, then rearbitrate from 0.
    randomize_data();
    req_valid = 4'b1010;
    tick();
    chk("wd_draw_seen", 32'(draw), 1);
    tick();
    draw_ready = 1'b0;
    tick();
    tick();
    chk("wd_busy", 32'(busy), 1);
    reset      = 1'b1;
    draw_ready = 1'b1;
    tick();
    chk("wdrst_busy", 32'(busy), 0);
    chk("wdrst_ack", 32'(req_ack), 0);
    chk("wdrst_draw", 32'(draw), 0);
    chk("wdrst_grant", 32'(grant_id), N - 1);
    chk("wdrst_terr", 32'(timeout_err), 0);
    chk("wdrst_x", 32'(x_origin), 0);
    reset    = 1'b0;
    last_g   = N - 1;
    exp_terr = 1'b0;
    xact(0, 1, 1, 1'b0);
    chk("rearb_grant", 32'(grant_id), 1);

    // Reset while the strobe is high kills the strobe.
    req_valid = 4'b0010;
    tick();
    chk("issue_draw_seen", 32'(draw), 1);
    reset = 1'b1;
    tick();
    chk("issrst_draw", 32'(draw), 0);
    chk("issrst_busy", 32'(busy), 0);
    chk("issrst_grant", 32'(grant_id), N - 1);
    reset  = 1'b0;
    last_g = N - 1;
    xact(0, 1, 1, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 20; it++) begin
      randomize_data();
      req_valid = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) hi = int'($urandom_range(TO - 1, TO + 2));
      else hi = int'($urandom_range(0, 6));
      lo = int'($urandom_range(1, 5));
      xact(hi, lo, 1, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
